// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, requests to send,
// shifts an odd-parity frame on device clock falling edges and checks the ack.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_REL
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_idx, bit_idx_n;
  logic [10:0]   frame, frame_n;
  logic          ack_q, ack_n;
  logic          ready_en;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          clk_s, dat_s, dev_fall, timed_out;

  // Synchronizers reset to the idle-high bus level so reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s     = clk_sync[1];
  assign dat_s     = dat_sync[1];
  assign dev_fall  = clk_prev & ~clk_s;
  assign timed_out = (cnt == CW'(TIMEOUT_CYCLES));

  // Holds cmd_ready low for as long as rst is asserted, high from the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      frame   <= '1;
      ack_q   <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      frame   <= frame_n;
      ack_q   <= ack_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CW'(1);
    bit_idx_n  = bit_idx;
    frame_n    = frame;
    ack_n      = ack_q;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    done       = 1'b0;
    error      = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (cmd_valid && ready_en) begin
          frame_n = {1'b1, ~^cmd_data, cmd_data, 1'b0};
          state_n = INHIBIT;
        end
      end

      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        // Final inhibit cycle overlaps the start bit before the clock is released.
        if (cnt == CW'(INHIBIT_CYCLES)) begin
          ps2_dat_oe = 1'b1;
          cnt_n      = '0;
          state_n    = RTS;
        end
      end

      RTS: begin
        ps2_dat_oe = 1'b1;
        if (dev_fall) begin
          cnt_n     = '0;
          bit_idx_n = 4'd1;
          state_n   = SHIFT;
        end else if (timed_out) begin
          ps2_dat_oe = 1'b0;
          error      = 1'b1;
          state_n    = IDLE;
        end
      end

      SHIFT: begin
        ps2_dat_oe = ~frame[bit_idx];
        if (dev_fall) begin
          cnt_n = '0;
          // The edge after the stop bit carries the device's ack level.
          if (bit_idx == 4'd10) begin
            ack_n   = dat_s;
            state_n = ACK;
          end else begin
            bit_idx_n = bit_idx + 4'd1;
          end
        end else if (timed_out) begin
          ps2_dat_oe = 1'b0;
          error      = 1'b1;
          state_n    = IDLE;
        end
      end

      ACK: begin
        cnt_n = '0;
        if (ack_q) begin
          error   = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = WAIT_REL;
        end
      end

      WAIT_REL: begin
        if (clk_s && dat_s) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (timed_out) begin
          error   = 1'b1;
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign cmd_ready = ready_en && (state == IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of
// the host, with expected frames and outcomes queued at command time.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 40;
  localparam int unsigned TO   = 300;
  localparam int          HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       busy, done, error;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;

  logic [9:0] exp_frame_q[$];
  int         exp_out_q[$];   // 0 = done, 1 = error, 2 = no pulse

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
    if (cmd_valid && cmd_ready && !rst) acc_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] data, input int outcome);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_ready_wait: got %b, want 1", cmd_ready);
    end
    cmd_data  = data;
    cmd_valid = 1'b1;
    exp_frame_q.push_back({1'b1, ~^data, data});
    exp_out_q.push_back(outcome);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && n < int'(INH) + 20) begin
      n++;
      tick(1);
    end
    n_vec++;
    if (n != int'(INH)) begin
      n_err++;
      $display("FAIL inhibit_len: got %0d cycles, want %0d", n, INH);
    end
    n_vec++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b11) begin
      n_err++;
      $display("FAIL start_cycle: got clk_oe,dat_oe=%b, want 11", {ps2_clk_oe, ps2_dat_oe});
    end
    tick(1);
    n_vec++;
    if ({ps2_clk_oe, ps2_dat_oe, busy, cmd_ready} !== 4'b0110) begin
      n_err++;
      $display("FAIL rts_state: got clk_oe,dat_oe,busy,ready=%b, want 0110",
               {ps2_clk_oe, ps2_dat_oe, busy, cmd_ready});
    end
  endtask

  task automatic dev_clock_bits(input int n, output logic [9:0] got);
    got = '0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      dev_clk = 1'b0;
      tick(HALF);
      got[i] = ps2_dat_in;
      dev_clk = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic check_frame(input logic [9:0] got, input int n, input string name);
    logic [9:0] expv;
    logic [9:0] m;
    expv = exp_frame_q.pop_front();
    m    = 10'h3FF >> (10 - n);
    n_vec++;
    if ((got & m) !== (expv & m)) begin
      n_err++;
      $display("FAIL %s_frame: got %b, want %b (mask %b)", name, got, expv, m);
    end
  endtask

  task automatic dev_ack(input logic ack_val, input string name);
    int obs = 2;
    int expo;
    dev_dat = ack_val;
    tick(2);
    dev_clk = 1'b0;
    for (int k = 0; k < 40 && obs == 2; k++) begin
      tick(1);
      if (done === 1'b1 || error === 1'b1) begin
        obs = (done === 1'b1) ? 0 : 1;
        n_vec++;
        if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
          n_err++;
          $display("FAIL %s_release: got clk_oe,dat_oe=%b, want 00", name, {ps2_clk_oe, ps2_dat_oe});
        end
      end else if (k == HALF) begin
        dev_clk = 1'b1;
        dev_dat = 1'b1;
      end
    end
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    expo = exp_out_q.pop_front();
    n_vec++;
    if (obs != expo) begin
      n_err++;
      $display("FAIL %s_outcome: got %0d, want %0d", name, obs, expo);
    end
    if (obs != 2) begin
      tick(1);
      n_vec++;
      if ({cmd_ready, busy, done, error} !== 4'b1000) begin
        n_err++;
        $display("FAIL %s_after: got ready,busy,done,error=%b, want 1000",
                 name, {cmd_ready, busy, done, error});
      end
    end
  endtask

  task automatic serve(input logic ack_val, input string name);
    logic [9:0] got;
    wait_start();
    dev_clock_bits(10, got);
    check_frame(got, 10, name);
    dev_ack(ack_val, name);
  endtask

  task automatic check_counts(input string name, input int d0, input int e0,
                              input int dexp, input int eexp);
    n_vec++;
    if (done_cnt - d0 != dexp || err_cnt - e0 != eexp) begin
      n_err++;
      $display("FAIL %s_pulses: got done=%0d error=%0d, want done=%0d error=%0d",
               name, done_cnt - d0, err_cnt - e0, dexp, eexp);
    end
  endtask

  task automatic test_reset();
    int d0, e0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({ps2_clk_oe, ps2_dat_oe, busy, done, error, cmd_ready} !== 6'b000000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, want 000000",
               {ps2_clk_oe, ps2_dat_oe, busy, done, error, cmd_ready});
    end
    tick(3);
    n_vec++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_held: got %b, want 0", cmd_ready);
    end
    rst = 1'b0;
    tick(1);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_after: got %b, want 1", cmd_ready);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    dev_clk = 1'b0;
    tick(HALF);
    dev_clk = 1'b1;
    tick(HALF);
    n_vec++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL idle_edges: got busy,ready=%b, want 01", {busy, cmd_ready});
    end
    check_counts("idle_edges", d0, e0, 0, 0);
  endtask

  task automatic test_send(input logic [7:0] data, input string name);
    int d0 = done_cnt;
    int e0 = err_cnt;
    send_cmd(data, 0);
    serve(1'b0, name);
    check_counts(name, d0, e0, 1, 0);
  endtask

  task automatic test_ack_error();
    int d0 = done_cnt;
    int e0 = err_cnt;
    send_cmd(8'h5A, 1);
    serve(1'b1, "nack");
    check_counts("nack", d0, e0, 0, 1);
  endtask

  task automatic test_timeout();
    logic [9:0] got;
    int d0 = done_cnt;
    int e0 = err_cnt;
    int obs = 2;
    int expo;
    send_cmd(8'h81, 1);
    wait_start();
    dev_clock_bits(4, got);
    check_frame(got, 4, "timeout");
    dev_clk = 1'b0;
    for (int k = 1; k <= int'(TO) + 3; k++) begin
      tick(1);
      if (k == HALF) dev_clk = 1'b1;
      if (k == int'(TO) + 2) begin
        n_vec++;
        if (error !== 1'b0) begin
          n_err++;
          $display("FAIL timeout_early: got error=%b, want 0", error);
        end
      end
      if (k == int'(TO) + 3) begin
        if (error === 1'b1) obs = 1;
        n_vec++;
        if ({error, ps2_clk_oe, ps2_dat_oe} !== 3'b100) begin
          n_err++;
          $display("FAIL timeout_fire: got error,clk_oe,dat_oe=%b, want 100",
                   {error, ps2_clk_oe, ps2_dat_oe});
        end
      end
    end
    expo = exp_out_q.pop_front();
    n_vec++;
    if (obs != expo) begin
      n_err++;
      $display("FAIL timeout_outcome: got %0d, want %0d", obs, expo);
    end
    tick(1);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_ready: got %b, want 1", cmd_ready);
    end
    check_counts("timeout", d0, e0, 0, 1);
  endtask

  task automatic test_reset_mid();
    logic [9:0] got;
    int d0 = done_cnt;
    int e0 = err_cnt;
    int obs, expo;
    send_cmd(8'hA5, 2);
    wait_start();
    dev_clock_bits(4, got);
    check_frame(got, 4, "rst_mid");
    n_vec++;
    if ({ps2_dat_oe, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL rst_mid_pre: got dat_oe,busy=%b, want 11", {ps2_dat_oe, busy});
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({ps2_clk_oe, ps2_dat_oe, busy, cmd_ready, done, error} !== 6'b000000) begin
      n_err++;
      $display("FAIL rst_mid_drop: got %b, want 000000",
               {ps2_clk_oe, ps2_dat_oe, busy, cmd_ready, done, error});
    end
    tick(3);
    rst = 1'b0;
    tick(1);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_ready: got %b, want 1", cmd_ready);
    end
    obs  = (done_cnt != d0) ? 0 : ((err_cnt != e0) ? 1 : 2);
    expo = exp_out_q.pop_front();
    n_vec++;
    if (obs != expo) begin
      n_err++;
      $display("FAIL rst_mid_outcome: got %0d, want %0d", obs, expo);
    end
    test_send(8'hFF, "after_rst");
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int e0 = err_cnt;
    int a0 = acc_cnt;
    cmd_data  = 8'h3C;
    cmd_valid = 1'b1;
    exp_frame_q.push_back({1'b1, ~^cmd_data, cmd_data});
    exp_out_q.push_back(0);
    tick(1);
    n_vec++;
    if ({busy, cmd_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_busy: got busy,ready=%b, want 10", {busy, cmd_ready});
    end
    serve(1'b0, "b2b_first");
    n_vec++;
    if (acc_cnt - a0 != 1) begin
      n_err++;
      $display("FAIL b2b_single: got %0d accepts, want 1", acc_cnt - a0);
    end
    exp_frame_q.push_back({1'b1, ~^cmd_data, cmd_data});
    exp_out_q.push_back(0);
    tick(1);
    cmd_valid = 1'b0;
    n_vec++;
    if (acc_cnt - a0 != 2 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second: got %0d accepts busy=%b, want 2 busy=1", acc_cnt - a0, busy);
    end
    serve(1'b0, "b2b_second");
    check_counts("b2b", d0, e0, 2, 0);
  endtask

  initial begin
    test_reset();
    test_send(8'hED, "send_ed");
    test_send(8'h00, "send_00");
    test_ack_error();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_vec++;
    if (both_cnt != 0) begin
      n_err++;
      $display("FAIL done_error_overlap: got %0d cycles, want 0", both_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
